mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_if.sv | 42 ++++
 rtl/mult_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mult_arbiter_if.sv
// Bundle of the two requester ports, the shared multiplier port and the
// result/status outputs of mult_arbiter.
// slave  : the arbiter side.
// master : the requesters plus the multiplier (drives requests and m_product).
// Handshake: a requester raises reqN with stable operands and holds both until
// it sees ackN high; ackN is a one-cycle pulse in the cycle after the accepting
// edge. rsp_valid is a one-cycle strobe with no back-pressure.
// fsm_state is a debug view of the arbiter FSM (0 IDLE, 1 LOAD, 2 RUN, 3 DONE).
interface mult_arbiter_if #(
    parameter int WIDTH = 6
);
    logic                   req0;
    logic                   req1;
    logic [WIDTH-1:0]       a0;
    logic [WIDTH-1:0]       b0;
    logic [WIDTH-1:0]       a1;
    logic [WIDTH-1:0]       b1;
    logic                   ack0;
    logic                   ack1;
    logic                   m_load;
    logic                   m_clr;
    logic [WIDTH-1:0]       m_a;
    logic [WIDTH-1:0]       m_b;
    logic [2*WIDTH-1:0]     m_product;
    logic                   rsp_valid;
    logic                   rsp_id;
    logic [2*WIDTH-1:0]     rsp_data;
    logic [15:0]            busy_cnt;
    logic [1:0]             fsm_state;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, m_product,
        output ack0, ack1, m_load, m_clr, m_a, m_b,
        output rsp_valid, rsp_id, rsp_data, busy_cnt, fsm_state
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, m_product,
        input  ack0, ack1, m_load, m_clr, m_a, m_b,
        input  rsp_valid, rsp_id, rsp_data, busy_cnt, fsm_state
    );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one multi-cycle multiplier between two
// requesters. One operation at a time: IDLE -> LOAD -> RUN (MULT_LAT cycles)
// -> DONE. Synchronous active-low reset.
// Optional feature: define MULT_ARB_BUSY_CNT_EN to enable the saturating
// busy-cycle counter on busy_cnt; otherwise busy_cnt is tied to 0.
module mult_arbiter #(
    parameter int WIDTH    = 6,
    parameter int MULT_LAT = 6
) (
    input  logic          clk,
    input  logic          rst,
    mult_arbiter_if.slave bus
);

    localparam int CW = (MULT_LAT < 2) ? 1 : $clog2(MULT_LAT);
    localparam logic [CW-1:0] RUN_LAST = CW'(MULT_LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    logic [CW-1:0]        run_cnt;
    logic                 rr_pri;      // 1: requester 1 wins a tie
    logic                 op_id;       // owner of the operation in flight
    logic                 ack0_q;
    logic                 ack1_q;
    logic                 m_load_q;
    logic                 m_clr_q;
    logic [WIDTH-1:0]     m_a_q;
    logic [WIDTH-1:0]     m_b_q;
    logic                 rsp_valid_q;
    logic                 rsp_id_q;
    logic [2*WIDTH-1:0]   rsp_data_q;
    logic                 grant_id;

    // Winner among the current requests; a lone request always wins.
    always_comb begin
        grant_id = 1'b0;
        if (bus.req0 && bus.req1) begin
            grant_id = rr_pri;
        end else if (bus.req1) begin
            grant_id = 1'b1;
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            run_cnt     <= '0;
            rr_pri      <= 1'b0;
            op_id       <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            m_load_q    <= 1'b0;
            m_clr_q     <= 1'b0;
            m_a_q       <= '0;
            m_b_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            m_load_q    <= 1'b0;
            m_clr_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        state    <= LOAD;
                        op_id    <= grant_id;
                        m_a_q    <= grant_id ? bus.a1 : bus.a0;
                        m_b_q    <= grant_id ? bus.b1 : bus.b0;
                        ack0_q   <= ~grant_id;
                        ack1_q   <= grant_id;
                        m_load_q <= 1'b1;
                        m_clr_q  <= 1'b1;
                        // The requester just served loses the next tie.
                        rr_pri   <= ~grant_id;
                    end
                end
                LOAD: begin
                    state   <= RUN;
                    run_cnt <= '0;
                end
                RUN: begin
                    if (run_cnt == RUN_LAST) begin
                        state       <= DONE;
                        rsp_data_q  <= bus.m_product;
                        rsp_id_q    <= op_id;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.m_load    = m_load_q;
    assign bus.m_clr     = m_clr_q;
    assign bus.m_a       = m_a_q;
    assign bus.m_b       = m_b_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.fsm_state = state;

`ifdef MULT_ARB_BUSY_CNT_EN
    logic [15:0] busy_q;

    // Saturating count of edges spent outside IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= 16'd0;
        end else if (state != IDLE && busy_q != 16'hFFFF) begin
            busy_q <= busy_q + 16'd1;
        end
    end

    assign bus.busy_cnt = busy_q;
`else
    assign bus.busy_cnt = 16'd0;
`endif

endmodule
